// File: rtl/ws2812_frame_sched_if.sv
// Bundle of frame control, pixel buffer read port and RZ_Code tx handshake.
// The scheduler uses the master modport; buffer, encoder and requester sit on slave.
interface ws2812_frame_sched_if #(
  parameter int ADDR_W = 8
);
  logic              frame_start;
  logic [ADDR_W-1:0] frame_len;
  logic              busy;
  logic              frame_done;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic              tx_en;
  logic [23:0]       RGB;
  logic              tx_done;

  modport master (
    input  frame_start, frame_len, pix_data, tx_done,
    output busy, frame_done, pix_rd, pix_addr, tx_en, RGB
  );

  modport slave (
    output frame_start, frame_len, pix_data, tx_done,
    input  busy, frame_done, pix_rd, pix_addr, tx_en, RGB
  );
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: streams frame_len pixels to RZ_Code, then holds the latch gap.
// Optional build macro WS_BRIGHTNESS_EN adds i_brightness and per-byte scaling in LOAD.
module ws2812_frame_sched #(
  parameter int ADDR_W   = 8,
  parameter int CLK_HZ   = 50_000_000,
  parameter int LATCH_US = 300
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef WS_BRIGHTNESS_EN
  input  logic [7:0]          i_brightness,
`endif
  ws2812_frame_sched_if.master bus
);

  localparam int LATCH_CYC = CLK_HZ / 1_000_000 * LATCH_US;
  localparam int CNT_W     = $clog2(LATCH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_LATCH, S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pix_rd;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_tx_en;
  logic [23:0]       r_rgb;
  logic              r_busy;
  logic              r_frame_done;

  logic [23:0]       w_scaled;
  logic [ADDR_W-1:0] w_last;
  logic [ADDR_W-1:0] w_next;

  assign w_last = r_len - ADDR_W'(1);
  assign w_next = r_idx + ADDR_W'(1);

`ifdef WS_BRIGHTNESS_EN
  // brightness+1 keeps 255 as an exact pass-through while 0 blanks the channel
  function automatic logic [7:0] scaleByte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  assign w_scaled = {scaleByte(bus.pix_data[23:16], i_brightness),
                     scaleByte(bus.pix_data[15:8],  i_brightness),
                     scaleByte(bus.pix_data[7:0],   i_brightness)};
`else
  assign w_scaled = bus.pix_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_pix_rd     <= 1'b0;
      r_pix_addr   <= '0;
      r_tx_en      <= 1'b0;
      r_rgb        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pix_rd     <= 1'b0;
      r_tx_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_len  <= bus.frame_len;
            r_idx  <= '0;
            r_busy <= 1'b1;
            // an empty frame still issues the latch gap so the chain resets
            if (bus.frame_len == '0) begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_LATCH;
            end else begin
              r_pix_rd   <= 1'b1;
              r_pix_addr <= '0;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_rgb   <= w_scaled;
          r_tx_en <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.tx_done) begin
            if (r_idx == w_last) begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_LATCH;
            end else begin
              r_idx      <= w_next;
              r_pix_rd   <= 1'b1;
              r_pix_addr <= w_next;
              r_state    <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          if (r_cnt == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_rd     = r_pix_rd;
  assign bus.pix_addr   = r_pix_addr;
  assign bus.tx_en      = r_tx_en;
  assign bus.RGB        = r_rgb;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched: pixel buffer + RZ_Code model, scoreboard queues.
// Build with WS_BRIGHTNESS_EN defined to also exercise the brightness scaling frames.
module tb_ws2812_frame_sched;

  localparam int ADDR_W   = 8;
  localparam int CLK_HZ   = 1_000_000;
  localparam int LATCH_US = 20;
  localparam int LC       = CLK_HZ / 1_000_000 * LATCH_US;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  int   txEnCount   = 0;
  int   doneCount   = 0;
  int   rzDoneCount = 0;
  int   lastRzDone  = -1000000;
  int   startCycle  = 0;
  int   rzDelay     = 720;
  int   monLen;

  logic        rzDone   = 1'b0;
  logic        spurDone = 1'b0;
  logic        rzBusy   = 1'b0;
  int          rzCnt    = 0;
  logic [23:0] rzCap    = '0;

  logic [23:0]       mem [0:255];
  logic [23:0]       expRgbQ[$];
  logic [ADDR_W-1:0] expAddrQ[$];
  int                expLenQ[$];

`ifdef WS_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  ws2812_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

  ws2812_frame_sched #(
    .ADDR_W  (ADDR_W),
    .CLK_HZ  (CLK_HZ),
    .LATCH_US(LATCH_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef WS_BRIGHTNESS_EN
    .i_brightness(brightness),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // pixel buffer: data appears the cycle after the read strobe
  always @(posedge clk) if (bus.pix_rd) bus.pix_data <= mem[bus.pix_addr];

  assign bus.tx_done = rzDone | spurDone;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
  endtask

  function automatic logic [23:0] expPixel(input logic [23:0] p);
`ifdef WS_BRIGHTNESS_EN
    logic [23:0] r;
    for (int k = 0; k < 3; k++)
      r[k*8 +: 8] = 8'((int'(p[k*8 +: 8]) * (int'(brightness) + 1)) / 256);
    return r;
`else
    return p;
`endif
  endfunction

  // RZ_Code model: answers each tx_en with a tx_done rzDelay cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rzBusy = 1'b0;
        rzDone = 1'b0;
      end else begin
        rzDone = 1'b0;
        if (rzBusy) begin
          if (rzCnt <= 1) begin
            rzDone = 1'b1;
            rzBusy = 1'b0;
            lastRzDone = cycle;
            rzDoneCount++;
            checkOutput("rgb_hold", bus.RGB, rzCap);
          end else begin
            rzCnt--;
          end
        end else if (bus.tx_en) begin
          rzBusy = 1'b1;
          rzCnt  = rzDelay;
          rzCap  = bus.RGB;
        end
      end
    end
  end

  // output monitor: pops the scoreboard whenever the DUT produces a strobe
  always @(negedge clk) begin
    if (!rst_n) begin
      expAddrQ.delete();
      expRgbQ.delete();
      expLenQ.delete();
    end else begin
      if (bus.pix_rd) begin
        if (expAddrQ.size() == 0) checkOutput("unexpected_pix_rd", 1, 0);
        else checkOutput("pix_addr", 32'(bus.pix_addr), 32'(expAddrQ.pop_front()));
      end
      if (bus.tx_en) begin
        txEnCount++;
        if (expRgbQ.size() == 0) checkOutput("unexpected_tx_en", 1, 0);
        else checkOutput("rgb", 32'(bus.RGB), 32'(expRgbQ.pop_front()));
        if (lastRzDone < startCycle) checkOutput("start_to_tx_en", cycle - startCycle, 3);
        else checkOutput("done_to_tx_en", cycle - lastRzDone, 3);
      end
      if (bus.frame_done) begin
        doneCount++;
        checkOutput("busy_in_done", bus.busy, 1);
        if (expLenQ.size() == 0) checkOutput("unexpected_frame_done", 1, 0);
        else begin
          monLen = expLenQ.pop_front();
          if (monLen == 0) checkOutput("latch_empty", cycle - startCycle, LC + 1);
          else checkOutput("latch_gap", cycle - lastRzDone, LC + 1);
        end
      end
    end
  end

  task automatic applyStimulus(input int len);
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      expAddrQ.push_back(ADDR_W'(i));
      expRgbQ.push_back(expPixel(mem[i]));
    end
    expLenQ.push_back(len);
    startCycle      = cycle;
    bus.frame_start = 1'b1;
    bus.frame_len   = ADDR_W'(len);
    @(negedge clk);
    bus.frame_start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
  endtask

  task automatic pulseIgnored(input int len);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.frame_len   = ADDR_W'(len);
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic waitFrameDone(input int budget, input bit pokeDone);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        seen = 1'b1;
        if (pokeDone) begin
          bus.frame_start = 1'b1;
          bus.frame_len   = ADDR_W'(4);
        end
      end
    end
    if (!seen) checkOutput("frame_done_timeout", 0, 1);
    @(negedge clk);
    bus.frame_start = 1'b0;
    checkOutput("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    int   txBase, doneBase, rzBase;
    logic [3:0]  ctrlOr;
    logic [23:0] rgbOr;
    logic [ADDR_W-1:0] addrOr;

    bus.frame_start = 1'b0;
    bus.frame_len   = '0;
    for (int i = 0; i < 256; i++) mem[i] = 24'(i * 24'h010203);
    mem[0] = 24'h112233;
    mem[1] = 24'h445566;
    mem[2] = 24'h778899;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    $display("[TB] reset held with frame_start toggling");
    ctrlOr = '0; rgbOr = '0; addrOr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.frame_start = ~bus.frame_start;
      bus.frame_len   = ADDR_W'(3);
      ctrlOr |= {bus.tx_en, bus.pix_rd, bus.busy, bus.frame_done};
      rgbOr  |= bus.RGB;
      addrOr |= bus.pix_addr;
    end
    checkOutput("reset_ctrl", 32'(ctrlOr), 0);
    checkOutput("reset_rgb", 32'(rgbOr), 0);
    checkOutput("reset_addr", 32'(addrOr), 0);
    bus.frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] three-pixel frame, 720-cycle encoder");
    rzDelay = 720;
    txBase = txEnCount; doneBase = doneCount;
    applyStimulus(3);
    waitFrameDone(3 * 800 + LC + 50, 1'b0);
    checkOutput("tx_en_count_3", txEnCount - txBase, 3);
    checkOutput("frame_done_count_3", doneCount - doneBase, 1);
    checkOutput("rgb_queue_drained", expRgbQ.size(), 0);

    $display("[TB] empty frame");
    txBase = txEnCount; doneBase = doneCount;
    applyStimulus(0);
    waitFrameDone(LC + 20, 1'b0);
    checkOutput("tx_en_count_0", txEnCount - txBase, 0);
    checkOutput("frame_done_count_0", doneCount - doneBase, 1);

    $display("[TB] dropped requests and spurious tx_done");
    rzDelay = 30;
    txBase = txEnCount; doneBase = doneCount; rzBase = rzDoneCount;
    applyStimulus(2);
    bus.frame_len = ADDR_W'(7);
    for (int i = 0; i < 200 && txEnCount < txBase + 1; i++) @(negedge clk);
    checkOutput("first_tx_en_seen", txEnCount >= txBase + 1, 1);
    repeat (5) @(negedge clk);
    pulseIgnored(5);
    for (int i = 0; i < 400 && rzDoneCount < rzBase + 2; i++) @(negedge clk);
    checkOutput("last_tx_done_seen", rzDoneCount >= rzBase + 2, 1);
    repeat (5) @(negedge clk);
    spurDone = 1'b1;
    @(negedge clk);
    spurDone = 1'b0;
    waitFrameDone(LC + 50, 1'b1);
    repeat (2 * LC) @(negedge clk);
    checkOutput("frame_done_count_drop", doneCount - doneBase, 1);
    checkOutput("tx_en_count_drop", txEnCount - txBase, 2);
    checkOutput("idle_after_drop", bus.busy, 0);

    $display("[TB] reset during second pixel");
    rzDelay = 40;
    txBase = txEnCount;
    applyStimulus(3);
    for (int i = 0; i < 200 && txEnCount < txBase + 2; i++) @(negedge clk);
    checkOutput("second_tx_en_seen", txEnCount >= txBase + 2, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_en", bus.tx_en, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_rgb", 32'(bus.RGB), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txBase = txEnCount; doneBase = doneCount;
    applyStimulus(2);
    waitFrameDone(2 * 60 + LC + 50, 1'b0);
    checkOutput("tx_en_count_restart", txEnCount - txBase, 2);
    checkOutput("frame_done_count_restart", doneCount - doneBase, 1);

`ifdef WS_BRIGHTNESS_EN
    $display("[TB] brightness scaling");
    rzDelay = 20;
    mem[0] = 24'hFF8002;
    mem[1] = 24'h123456;
    for (int b = 0; b < 3; b++) begin
      brightness = (b == 0) ? 8'd127 : ((b == 1) ? 8'd255 : 8'd0);
      txBase = txEnCount;
      applyStimulus(2);
      waitFrameDone(2 * 40 + LC + 50, 1'b0);
      checkOutput("tx_en_count_bright", txEnCount - txBase, 2);
    end
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
